// File: rtl/lfsr_step_ctrl.sv
// Front-panel controller for an 8-bit shift-register generator: debounces
// the step button and the load/auto switches, sequences the generator's
// en/din pins, counts steps and shows the generator value on two digits.
// Latency: raw input edge to debounced level is 2 + DB_MAX cycles. The
// request pulse follows one cycle later, and the STEP/LOAD state one cycle
// after that.
// Backpressure: none. Requests that arrive while a LOAD or STEP is in
// progress are dropped, not queued.
// Ports:
//   clk, rst_n        - system clock, async active-low reset
//   btn, load_sw,     - raw asynchronous panel inputs
//   auto_sw
//   seed              - value loaded on a load_sw rising edge
//   lfsr_q            - generator output fed back
//   lfsr_en, lfsr_din - generator control (din is loaded whenever en is 0)
//   step_cnt          - steps since the last load
//   hex1, hex0        - active-low 7-segment codes (bit0=a .. bit6=g)
module lfsr_step_ctrl #(
  parameter int DB_MAX  = 500000,
  parameter int DB_W    = 19,
  parameter int RUN_DIV = 25000000,
  parameter int RUN_W   = 25
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn,
  input  logic       load_sw,
  input  logic       auto_sw,
  input  logic [7:0] seed,
  input  logic [7:0] lfsr_q,
  output logic       lfsr_en,
  output logic [7:0] lfsr_din,
  output logic [7:0] step_cnt,
  output logic [6:0] hex1,
  output logic [6:0] hex0
);

  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_MAX - 1);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(RUN_DIV - 1);

  typedef enum logic [1:0] {INIT, IDLE, LOAD, STEP} state_t;

  // Bit 0 = btn, bit 1 = load_sw, bit 2 = auto_sw
  logic [2:0]      raw;
  logic [2:0]      sync1;
  logic [2:0]      sync2;
  logic [2:0]      db;
  logic [2:0]      db_d;
  logic [DB_W-1:0] db_cnt [3];

  logic [RUN_W-1:0] run_cnt;
  logic             step_req;
  logic             load_req;
  logic             run_req;

  state_t state;
  state_t state_nxt;

  assign raw = {auto_sw, load_sw, btn};

  // Two-flop synchronisers followed by per-input debouncers. The debounced
  // level changes only after the synchronised input has disagreed with it
  // for DB_MAX consecutive cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      db_d  <= '0;
      for (int i = 0; i < 3; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      db_d  <= db;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db[i]     <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign step_req = db[0] & ~db_d[0];
  assign load_req = db[1] & ~db_d[1];

  // Auto-run divider: free-runs only while the debounced switch is on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt <= '0;
    end else if (!db[2] || run_cnt == RUN_LAST) begin
      run_cnt <= '0;
    end else begin
      run_cnt <= run_cnt + 1'b1;
    end
  end

  assign run_req = db[2] && (run_cnt == RUN_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
    end else begin
      state <= state_nxt;
    end
  end

  // lfsr_din defaults to lfsr_q so the generator holds its value whenever
  // it is not being stepped or loaded. INIT drives the seed, so the
  // generator keeps loading it for as long as reset is held.
  always_comb begin
    state_nxt = state;
    lfsr_en   = 1'b0;
    lfsr_din  = lfsr_q;
    case (state)
      INIT: begin
        lfsr_din  = seed;
        state_nxt = LOAD;
      end
      IDLE: begin
        if (load_req) begin
          state_nxt = LOAD;
        end else if (step_req || run_req) begin
          state_nxt = STEP;
        end
      end
      LOAD: begin
        lfsr_din  = seed;
        state_nxt = IDLE;
      end
      STEP: begin
        lfsr_en   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt <= 8'h00;
    end else if (state == LOAD) begin
      step_cnt <= 8'h00;
    end else if (state == STEP) begin
      step_cnt <= step_cnt + 8'd1;
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hex1 <= 7'h7F;
      hex0 <= 7'h7F;
    end else begin
      hex1 <= seg7(lfsr_q[7:4]);
      hex0 <= seg7(lfsr_q[3:0]);
    end
  end

endmodule

// File: tb/tb_lfsr_step_ctrl.sv
// Bench for lfsr_step_ctrl paired with a model of the 8-bit generator.
module tb_lfsr_step_ctrl;
  localparam int DB_MAX  = 4;
  localparam int DB_W    = 3;
  localparam int RUN_DIV = 8;
  localparam int RUN_W   = 4;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       btn     = 1'b0;
  logic       load_sw = 1'b0;
  logic       auto_sw = 1'b0;
  logic [7:0] seed    = 8'h01;
  logic [7:0] lfsr_q;
  logic       lfsr_en;
  logic [7:0] lfsr_din;
  logic [7:0] step_cnt;
  logic [6:0] hex1;
  logic [6:0] hex0;

  lfsr_step_ctrl #(
    .DB_MAX(DB_MAX), .DB_W(DB_W), .RUN_DIV(RUN_DIV), .RUN_W(RUN_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn(btn), .load_sw(load_sw), .auto_sw(auto_sw),
    .seed(seed), .lfsr_q(lfsr_q), .lfsr_en(lfsr_en), .lfsr_din(lfsr_din),
    .step_cnt(step_cnt), .hex1(hex1), .hex0(hex0)
  );

  always #5 clk = ~clk;

  // Generator: shift right, feedback into bit 7, all-zero state forced out.
  function automatic logic [7:0] lfsr_next(input logic [7:0] q);
    logic fb;
    fb = (q == 8'h00) ? 1'b1 : (q[0] ^ q[2] ^ q[3] ^ q[4]);
    return {fb, q[7:1]};
  endfunction

  logic [7:0] gen_q;
  assign lfsr_q = gen_q;
  always @(posedge clk) gen_q <= lfsr_en ? lfsr_next(gen_q) : lfsr_din;

  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  typedef struct {
    logic [7:0] val;
    logic [6:0] h1;
    logic [6:0] h0;
  } hex_vec_t;
  hex_vec_t vecs [8];

  int checks = 0;
  int errors = 0;
  int en_pulses = 0;
  int long_pulses = 0;
  logic en_prev = 1'b0;

  always @(negedge clk) begin
    if (lfsr_en === 1'b1) begin
      en_pulses++;
      if (en_prev) long_pulses++;
    end
    en_prev = (lfsr_en === 1'b1);
  end

  logic [7:0] exp_q;
  int         exp_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_step();
    exp_q   = lfsr_next(exp_q);
    exp_cnt = (exp_cnt + 1) % 256;
  endtask

  task automatic check_state(input string name);
    chk({name, "_q"}, 32'(lfsr_q), 32'(exp_q));
    chk({name, "_cnt"}, 32'(step_cnt), 32'(exp_cnt));
  endtask

  task automatic press(input int hi, input int lo);
    btn = 1'b1;
    repeat (hi) tick();
    btn = 1'b0;
    repeat (lo) tick();
  endtask

  // One clean press with random hold times; expects exactly one step.
  task automatic step_press(input string name);
    int p0;
    p0 = en_pulses;
    press($urandom_range(6, 12), $urandom_range(10, 14));
    model_step();
    chk({name, "_pulses"}, 32'(en_pulses - p0), 32'd1);
    check_state(name);
  endtask

  task automatic do_load(input logic [7:0] v);
    int p0;
    p0 = en_pulses;
    seed = v;
    load_sw = 1'b1;
    repeat (12) tick();
    load_sw = 1'b0;
    repeat (12) tick();
    exp_q = v;
    exp_cnt = 0;
    chk("load_pulses", 32'(en_pulses - p0), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int         p0;
    int         found;
    int         lat;
    logic [7:0] prev_q;
    int         first;
    int         prev;
    int         npulse;
    int         bad_gap;
    int         exp_n;

    vecs[0] = '{8'h01, 7'b1000000, 7'b1111001};
    vecs[1] = '{8'h23, 7'b0100100, 7'b0110000};
    vecs[2] = '{8'h45, 7'b0011001, 7'b0010010};
    vecs[3] = '{8'h67, 7'b0000010, 7'b1111000};
    vecs[4] = '{8'h89, 7'b0000000, 7'b0010000};
    vecs[5] = '{8'hAB, 7'b0001000, 7'b0000011};
    vecs[6] = '{8'hCD, 7'b1000110, 7'b0100001};
    vecs[7] = '{8'hEF, 7'b0000110, 7'b0001110};

    // Reset and init
    repeat (3) tick();
    chk("rst_en", 32'(lfsr_en), 32'd0);
    chk("rst_din", 32'(lfsr_din), 32'h01);
    chk("rst_cnt", 32'(step_cnt), 32'h00);
    chk("rst_hex1", 32'(hex1), 32'h7F);
    chk("rst_hex0", 32'(hex0), 32'h7F);
    chk("rst_q", 32'(lfsr_q), 32'h01);
    rst_n = 1'b1;
    repeat (4) tick();
    exp_q = 8'h01;
    exp_cnt = 0;
    check_state("init");
    chk("init_hex1", 32'(hex1), 32'(7'b1000000));
    chk("init_hex0", 32'(hex0), 32'(7'b1111001));

    // First press: latency, hex lag and hold-gives-one-step
    p0 = en_pulses;
    found = 0;
    lat = 0;
    btn = 1'b1;
    for (int i = 1; i <= 20 && found == 0; i++) begin
      tick();
      if (lfsr_en) begin
        found = 1;
        lat = i;
      end
    end
    chk("btn_latency", 32'(lat), 32'(2 + DB_MAX + 1));
    chk("step_pre_q", 32'(lfsr_q), 32'(exp_q));
    prev_q = exp_q;
    tick();
    model_step();
    check_state("step1");
    chk("step1_literal", 32'(lfsr_q), 32'h80);
    chk("hex_lag", 32'(hex1), 32'(seg_tab[prev_q[7:4]]));
    tick();
    chk("hex_new1", 32'(hex1), 32'(seg_tab[exp_q[7:4]]));
    chk("hex_new0", 32'(hex0), 32'(seg_tab[exp_q[3:0]]));
    repeat (20) tick();
    btn = 1'b0;
    repeat (12) tick();
    chk("hold_one_step", 32'(en_pulses - p0), 32'd1);

    step_press("step2");
    step_press("step3");
    chk("seq_q", 32'(lfsr_q), 32'h20);
    chk("seq_cnt", 32'(step_cnt), 32'd3);
    chk("seq_hex1", 32'(hex1), 32'(7'b0100100));
    chk("seq_hex0", 32'(hex0), 32'(7'b1000000));

    // Bounce rejection
    p0 = en_pulses;
    for (int i = 0; i < 10; i++) begin
      btn = (i % 2 == 0);
      repeat (2) tick();
    end
    chk("bounce_none", 32'(en_pulses - p0), 32'd0);
    btn = 1'b1;
    repeat (12) tick();
    btn = 1'b0;
    repeat (12) tick();
    model_step();
    chk("bounce_one", 32'(en_pulses - p0), 32'd1);
    chk("bounce_q", 32'(lfsr_q), 32'h10);
    step_press("after_bounce");
    chk("after_bounce_lit", 32'(lfsr_q), 32'h88);

    // All-zero recovery
    do_load(8'h00);
    check_state("zero_load");
    step_press("zero_step");
    chk("zero_recover", 32'(lfsr_q), 32'h80);

    // Load and step edges on the same cycle: load wins
    p0 = en_pulses;
    seed = 8'h5A;
    btn = 1'b1;
    load_sw = 1'b1;
    repeat (12) tick();
    btn = 1'b0;
    load_sw = 1'b0;
    repeat (12) tick();
    exp_q = 8'h5A;
    exp_cnt = 0;
    chk("simul_pulses", 32'(en_pulses - p0), 32'd0);
    check_state("simul");

    // Table-driven decode vectors
    for (int i = 0; i < 8; i++) begin
      do_load(vecs[i].val);
      chk("tab_q", 32'(lfsr_q), 32'(vecs[i].val));
      chk("tab_hex1", 32'(hex1), 32'(vecs[i].h1));
      chk("tab_hex0", 32'(hex0), 32'(vecs[i].h0));
    end

    // Auto-run: switch on, then off after tick 54
    first = -1;
    prev = -1;
    npulse = 0;
    bad_gap = 0;
    auto_sw = 1'b1;
    for (int i = 1; i <= 70; i++) begin
      tick();
      if (lfsr_en) begin
        npulse++;
        if (first < 0) first = i;
        else if (i - prev != RUN_DIV) bad_gap++;
        prev = i;
        model_step();
      end
      if (i == 54) auto_sw = 1'b0;
    end
    exp_n = 0;
    for (int t = 2 + DB_MAX + RUN_DIV; t <= 54 + 2 + DB_MAX; t += RUN_DIV) exp_n++;
    chk("auto_first", 32'(first), 32'(2 + DB_MAX + RUN_DIV));
    chk("auto_count", 32'(npulse), 32'(exp_n));
    chk("auto_gap", 32'(bad_gap), 32'd0);
    check_state("auto");

    // Randomized mix of loads, glitches and presses
    for (int r = 0; r < 40; r++) begin
      case ($urandom_range(0, 5))
        0: do_load(8'($urandom));
        1: begin
          p0 = en_pulses;
          press($urandom_range(1, DB_MAX - 1), 10);
          chk("rnd_glitch", 32'(en_pulses - p0), 32'd0);
        end
        default: step_press("rnd_step");
      endcase
      check_state("rnd");
    end

    // 256 steps wrap the counter
    do_load(8'($urandom));
    for (int n = 1; n <= 256; n++) begin
      step_press("wrap_step");
      if (n == 255) chk("wrap_ff", 32'(step_cnt), 32'hFF);
    end
    chk("wrap_zero", 32'(step_cnt), 32'h00);

    // Reset in the middle of a STEP
    found = 0;
    btn = 1'b1;
    for (int i = 1; i <= 20 && found == 0; i++) begin
      tick();
      if (lfsr_en) found = 1;
    end
    chk("midrst_found", 32'(found), 32'd1);
    seed = 8'hC3;
    rst_n = 1'b0;
    btn = 1'b0;
    #1;
    chk("midrst_en", 32'(lfsr_en), 32'd0);
    chk("midrst_din", 32'(lfsr_din), 32'hC3);
    chk("midrst_cnt", 32'(step_cnt), 32'h00);
    chk("midrst_hex1", 32'(hex1), 32'h7F);
    tick();
    chk("midrst_q", 32'(lfsr_q), 32'hC3);
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    exp_q = 8'hC3;
    exp_cnt = 0;
    check_state("post_rst");

    chk("no_long_pulse", 32'(long_pulses), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lfsr_step_ctrl.md
# lfsr_step_ctrl

Front-panel controller for the 8-bit shift-register random generator. It debounces a step button, a seed-load switch and an auto-run switch, and drives the generator's `en`/`din` pins. The generator loads `din` whenever `en` is low, so in idle the controller feeds the current value back on `din` to hold it. It also takes the generator's `dout` back, keeps a step count, and decodes the value onto two active-low 7-segment digits.

## Interface
- `DB_MAX`, default 500000: number of consecutive stable cycles before a debounced input changes (10 ms at 50 MHz).
- `DB_W`, default 19: width of the debounce counters; must satisfy 2^DB_W > DB_MAX.
- `RUN_DIV`, default 25000000: auto-run step period in cycles.
- `RUN_W`, default 25: width of the auto-run counter.
- `clk` in 1: single system clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `btn` in 1: raw step push-button, active-high, asynchronous.
- `load_sw` in 1: raw seed-load switch; its rising edge loads the seed. Asynchronous.
- `auto_sw` in 1: raw auto-run switch; level 1 = step every `RUN_DIV` cycles.
- `seed` in 8: seed value, quasi-static.
- `lfsr_q` in 8: generator output (`dout`).
- `lfsr_en` out 1: drives generator `en`.
- `lfsr_din` out 8: drives generator `din`.
- `step_cnt` out 8: number of steps since the last load.
- `hex1` out 7: active-low segments for `lfsr_q[7:4]`, bit0=a … bit6=g.
- `hex0` out 7: active-low segments for `lfsr_q[3:0]`, same bit mapping.

## Operation
- **Input synchronisers.** Each raw input (`btn`, `load_sw`, `auto_sw`) passes a 2-flop synchroniser. All three reset to 0.
- **Debouncer, per input.**
  - Keep a debounced level `db` and a counter.
  - Counter clears when the synchronised value equals `db`; it increments while they differ.
  - When the counter reaches `DB_MAX-1` with the mismatch still present, `db` takes the new value and the counter clears.
  - `db` and the counter reset to 0.
- **Edge detect.** `step_req` and `load_req` are one-cycle pulses on rising edges of debounced `btn` and `load_sw`.
- **Auto-run.**
  - While debounced `auto_sw`=1, the counter counts 0..`RUN_DIV-1` and pulses `run_req` on wrap.
  - The counter is held at 0 while `auto_sw`=0.
- **FSM states:**
  - `INIT`, the reset state.
  - `IDLE`: drive `lfsr_en`=0 and `lfsr_din`=`lfsr_q` (hold).
  - `LOAD`: drive `lfsr_en`=0 and `lfsr_din`=`seed`.
  - `STEP`: drive `lfsr_en`=1, with `lfsr_din`=`lfsr_q` (don't-care).
- **FSM transitions:**
  - `INIT`→`LOAD` on the first clock after reset release.
  - `IDLE`→`LOAD` on `load_req`.
  - `IDLE`→`STEP` on (`step_req` or `run_req`) when there is no `load_req`.
  - `LOAD`→`IDLE` and `STEP`→`IDLE` unconditionally; each lasts exactly one cycle.
- **Simultaneous events.**
  - `load_req` beats `step_req`/`run_req`, and the step is discarded.
  - Requests arriving while in `LOAD` or `STEP` are discarded; no queue is kept.
  - `step_req` and `run_req` together produce one step.
- **Step counter.** `step_cnt` clears in `LOAD`, increments by 1 in `STEP`, and wraps 0xFF→0x00.
- **Hex decode.**
  - `hex1`/`hex0` are registered decodes of `lfsr_q`, updated every cycle.
  - Codes, written g..a: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.

## Timing
- **Reset values.**
  - FSM=`INIT`, `lfsr_en`=0, `lfsr_din`=`seed`, `step_cnt`=0x00, `hex1`=`hex0`=7'h7F (blank).
  - The generator therefore loads `seed` on every clock edge while reset is held.
- **Mid-operation reset.** Asserting `rst_n` aborts any state immediately and asynchronously; outputs take their reset values.
- **Button path latency.**
  - Raw `btn` rise held stable: debounced level rises at edge 2+`DB_MAX`, `step_req` is high the following cycle, and `STEP` (`lfsr_en`=1) follows one cycle later.
  - The generator updates on the edge ending `STEP`. `step_cnt` updates on the same edge.
- **Bounce rejection.** Glitches shorter than `DB_MAX` cycles produce no step.
- **Button hold.** Holding `btn` gives exactly one step; release and re-press is needed for another.
- **Hex latency.** `hex*` lag `lfsr_q` by one cycle.
- **Auto-run rate.** One step per `RUN_DIV` cycles: `run_req` at counter wrap, `STEP` on the next cycle.

## Test plan
Benches use `DB_MAX`=4, `RUN_DIV`=8 and pair this block with the generator.
- **Reset and init.** Reset 3 cycles with `seed`=0x01, then release → `lfsr_q`=0x01, `step_cnt`=0, `hex1`=1000000, `hex0`=1111001.
- **Stepped sequence.** Three clean `btn` presses, each held ≥8 cycles → `lfsr_q` 0x80, 0x40, 0x20, each with exactly one 1-cycle `lfsr_en`; `step_cnt`=3; `hex1`/`hex0` for 0x20 = 0100100 / 1000000.
- **Bounce rejection.** `btn` toggled every 2 cycles for 20 cycles, then held high → exactly one step; 0x20→0x10, then next press 0x10→0x88.
- **All-zero recovery and simultaneous events.**
  - `seed`=0x00 with a `load_sw` rise → `lfsr_q`=0x00 and `step_cnt`=0.
  - One step → 0x80.
  - `load_sw` and `btn` debounced edges on the same cycle → load only; `lfsr_q`=`seed` and `step_cnt`=0.
- **Auto-run.** `auto_sw`=1 for 40 cycles after debounce → `lfsr_en` pulses exactly every 8 cycles; `step_cnt` = number of pulses.
- **Wrap and mid-step reset.**
  - 256 steps → `step_cnt` wraps to 0x00.
  - `rst_n` low during `STEP` → `lfsr_en` drops immediately and `lfsr_q` reloads `seed`.
